fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_generic.sv | 59 +++++
 rtl/fifo_stream_reader.sv | 112 +++++++++++
 tb/tb_fifo_stream_reader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO stream reader: output-buffer occupancy encoding.
// Latency: none (types and a pure helper function only).
// Backpressure: not applicable.
package fifo_pkg;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Number of entries held in the buffer for a given occupancy state.
  function automatic logic [1:0] occ_count(input occ_e s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_generic.sv
// Generic synchronous FIFO; registered read data appears the cycle after an accepted read.
// Latency: write->o_empty low 1 cycle; read->o_rd_data 1 cycle.
// Backpressure: writes ignored while o_full, reads ignored while o_empty.
//
// Ports:
//   clk, i_rst            : clock, synchronous active-high reset (pointers only)
//   i_wr, i_wr_data, o_full : write side
//   i_rd, o_rd_data, o_empty: read side; o_empty is combinational from the count
module fifo_generic #(
  parameter int DataWidth = 32,
  parameter int Depth     = 16   // power of two so the pointers wrap naturally
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_wr,
  input  logic [DataWidth-1:0] i_wr_data,
  output logic                 o_full,
  input  logic                 i_rd,
  output logic [DataWidth-1:0] o_rd_data,
  output logic                 o_empty
);

  localparam int AddrWidth = $clog2(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rd_data_q;
  logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrWidth:0]   count_q;
  logic                 wr_en, rd_en;

  assign o_empty   = (count_q == '0);
  assign o_full    = (count_q == (AddrWidth+1)'(Depth));
  assign wr_en     = i_wr && !o_full;
  assign rd_en     = i_rd && !o_empty;
  assign o_rd_data = rd_data_q;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AddrWidth+1)'(1);
        2'b01:   count_q <= count_q - (AddrWidth+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream through a 2-entry skid buffer.
// Latency: 2 cycles read issue -> o_valid; 1 beat/cycle sustained with i_ready held high.
// Backpressure: reads stop once buffered + in-flight words would exceed 2; o_data holds while stalled.
//
// Ports:
//   clk, i_rst                 : clock, synchronous active-high reset
//   i_enable                   : permits new FIFO reads
//   i_fifo_empty, o_fifo_read,
//   i_fifo_data                : FIFO read side (data valid the cycle after a read)
//   o_valid, o_data, i_ready   : output stream
//   o_beat_count               : beats delivered since reset (wraps)
//   o_idle                     : nothing buffered and no read in flight
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int CountWidth = 16
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_read,
  input  logic [DataWidth-1:0]  i_fifo_data,
  output logic                  o_valid,
  output logic [DataWidth-1:0]  o_data,
  input  logic                  i_ready,
  output logic [CountWidth-1:0] o_beat_count,
  output logic                  o_idle
);

  occ_e                  state_q, state_d;
  logic                  inflight_q;
  logic [DataWidth-1:0]  head_q, head_d;
  logic [DataWidth-1:0]  tail_q, tail_d;
  logic [CountWidth-1:0] beat_cnt_q, beat_cnt_d;

  logic       pop;
  logic       capture;
  logic [2:0] occ_after;

  assign pop     = o_valid && i_ready;
  assign capture = inflight_q;

  // Occupancy after this edge once the in-flight word lands; a new read is
  // only safe if its data will still find a free slot next cycle.
  assign occ_after = {1'b0, occ_count(state_q)} + {2'b00, inflight_q} - {2'b00, pop};

  // Gated by reset so the paired FIFO is never popped while both are being cleared.
  assign o_fifo_read = !i_rst && i_enable && !i_fifo_empty && (occ_after < 3'd2);

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    beat_cnt_d = pop ? beat_cnt_q + CountWidth'(1) : beat_cnt_q;

    unique case (state_q)
      EMPTY: begin
        if (capture) begin
          head_d  = i_fifo_data;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({pop, capture})
          2'b11: head_d = i_fifo_data;            // head replaced, stays ONE
          2'b10: state_d = EMPTY;
          2'b01: begin
            tail_d  = i_fifo_data;
            state_d = TWO;
          end
          default: ;
        endcase
      end
      TWO: begin
        // Capture without pop cannot occur here: the read gate never lets a
        // third word be in flight while both slots are full.
        if (pop) begin
          head_d = tail_q;
          if (capture) tail_d = i_fifo_data;
          else         state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= o_fifo_read;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Data slots carry no reset; they are only observed while o_valid is high.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign o_valid      = (state_q != EMPTY);
  assign o_data       = head_q;
  assign o_beat_count = beat_cnt_q;
  assign o_idle       = (state_q == EMPTY) && !inflight_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: source FIFO + reader, scoreboard of written words vs delivered beats.
// Latency: not applicable.
// Backpressure: bench drives i_ready directly (toggling, random, held low).
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst, en, rdy, wr;
  logic [31:0] wr_data;
  logic        fifo_empty, fifo_full, rd;
  logic [31:0] fifo_rdata, dat;
  logic        vld, idle;
  logic [3:0]  cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  int          model_beats = 0;
  logic        stall_prev  = 1'b0;
  logic [31:0] stall_dat   = '0;

  always #5 clk = ~clk;

  fifo_generic #(.DataWidth(32), .Depth(32)) u_src (
    .clk(clk), .i_rst(rst), .i_wr(wr), .i_wr_data(wr_data), .o_full(fifo_full),
    .i_rd(rd), .o_rd_data(fifo_rdata), .o_empty(fifo_empty)
  );

  fifo_stream_reader #(.DataWidth(32), .CountWidth(4)) dut (
    .clk(clk), .i_rst(rst), .i_enable(en), .i_fifo_empty(fifo_empty),
    .o_fifo_read(rd), .i_fifo_data(fifo_rdata), .o_valid(vld), .o_data(dat),
    .i_ready(rdy), .o_beat_count(cnt), .o_idle(idle)
  );

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, got, exp, $time);
  endfunction

  // Scoreboard: every accepted FIFO write must come out once, in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_beats = 0;
      stall_prev  = 1'b0;
    end else begin
      if (wr && !fifo_full) exp_q.push_back(wr_data);
      chk("no_underflow", 32'(rd && fifo_empty), 32'd0);
      chk("beat_count", 32'(cnt), 32'(model_beats % 16));
      if (stall_prev) begin
        chk("hold_valid", 32'(vld), 32'd1);
        chk("hold_data", dat, stall_dat);
      end
      if (vld && rdy) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
        else chk("pop_data", dat, exp_q.pop_front());
        model_beats++;
      end
      stall_prev = vld && !rdy;
      stall_dat  = dat;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; rdy = 1'b0; wr = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] d);
    wr = 1'b1; wr_data = d;
    cyc();
    wr = 1'b0;
  endtask

  // mode 0: ready toggles 1,0,1,0; mode 1: random enable/ready.
  task automatic run_stream(input int nwords, input int mode, input string nm);
    int sent = 0;
    for (int c = 0; c < 5000; c++) begin
      if (sent == nwords && exp_q.size() == 0) break;
      if (mode == 0) begin
        en  = 1'b1;
        rdy = (c % 2 == 0);
      end else if (sent < nwords) begin
        en  = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 1) != 0);
      end else begin
        en = 1'b1; rdy = 1'b1;
      end
      wr = (sent < nwords) && !fifo_full && ($urandom_range(0, 3) != 0);
      wr_data = $urandom;
      if (wr) sent++;
      cyc();
    end
    wr = 1'b0;
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_sent"}, 32'(sent), 32'(nwords));
  endtask

  initial begin
    int reads;
    rst = 1'b1; en = 1'b0; rdy = 1'b0; wr = 1'b0; wr_data = '0;

    // Reset state and a three-word burst.
    do_reset();
    @(negedge clk);
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_read", 32'(rd), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    write_word(32'h11); write_word(32'h22); write_word(32'h33);
    rdy = 1'b1; en = 1'b1;
    @(negedge clk); chk("t1_read_c0", 32'(rd), 32'd1); chk("t1_vld_c0", 32'(vld), 32'd0);
    cyc(); @(negedge clk); chk("t1_vld_c1", 32'(vld), 32'd0);
    cyc(); @(negedge clk); chk("t1_vld_c2", 32'(vld), 32'd1); chk("t1_dat_c2", dat, 32'h11);
    cyc(); @(negedge clk); chk("t1_dat_c3", dat, 32'h22);
    cyc(); @(negedge clk); chk("t1_dat_c4", dat, 32'h33);
    cyc(); @(negedge clk); chk("t1_vld_c5", 32'(vld), 32'd0);
    cyc(); @(negedge clk); chk("t1_count", 32'(cnt), 32'd3); chk("t1_idle", 32'(idle), 32'd1);
    cyc();

    // Backpressure: eight words, ready low for ten cycles.
    do_reset();
    for (int i = 0; i < 8; i++) write_word(32'h100 + 32'(i));
    rdy = 1'b0; en = 1'b1; reads = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); reads += int'(rd);
      cyc();
    end
    chk("t2_reads", 32'(reads), 32'd2);
    @(negedge clk); chk("t2_vld", 32'(vld), 32'd1); chk("t2_head", dat, 32'h100);
    cyc(); rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("t2_nogap", 32'(vld), 32'd1);
      cyc();
    end
    @(negedge clk); chk("t2_vld_end", 32'(vld), 32'd0); chk("t2_count", 32'(cnt), 32'd8);
    cyc();

    // Ready toggling over 100 random words, then fully random traffic.
    do_reset();
    run_stream(100, 0, "t3");
    @(negedge clk); chk("t3_count", 32'(cnt), 32'd4);   // 100 mod 16
    cyc();
    do_reset();
    run_stream(200, 1, "t3b");
    @(negedge clk); chk("t3b_count", 32'(cnt), 32'd8);  // 200 mod 16
    cyc();

    // Empty FIFO: no reads; single word appears two cycles after empty falls.
    do_reset();
    en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("t4_no_read", 32'(rd), 32'd0);
      cyc();
    end
    write_word(32'hA5);
    @(negedge clk); chk("t4_read", 32'(rd), 32'd1); chk("t4_vld0", 32'(vld), 32'd0);
    cyc(); @(negedge clk); chk("t4_vld1", 32'(vld), 32'd0);
    cyc(); @(negedge clk); chk("t4_vld2", 32'(vld), 32'd1); chk("t4_dat", dat, 32'hA5);
    cyc(); @(negedge clk); chk("t4_vld3", 32'(vld), 32'd0); chk("t4_idle", 32'(idle), 32'd1);
    cyc();

    // Enable dropped right as a read issues: that word still arrives, nothing more.
    do_reset();
    for (int i = 0; i < 4; i++) write_word(32'h200 + 32'(i));
    rdy = 1'b0; en = 1'b1;
    @(negedge clk); chk("t5_read", 32'(rd), 32'd1);
    cyc(); en = 1'b0; reads = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); reads += int'(rd);
      cyc();
    end
    chk("t5_no_reads", 32'(reads), 32'd0);
    @(negedge clk); chk("t5_vld", 32'(vld), 32'd1); chk("t5_dat", dat, 32'h200);
    cyc(); rdy = 1'b1;
    @(negedge clk); chk("t5_pop", 32'(vld), 32'd1);
    cyc(); @(negedge clk); chk("t5_vld_end", 32'(vld), 32'd0); chk("t5_count", 32'(cnt), 32'd1);
    cyc();

    // Reset with a full buffer, then a 17-beat run wrapping the 4-bit counter.
    do_reset();
    for (int i = 0; i < 6; i++) write_word(32'h300 + 32'(i));
    en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    @(negedge clk); chk("t6_vld_pre", 32'(vld), 32'd1); chk("t6_cnt_pre", 32'(cnt), 32'd2);
    cyc(); rst = 1'b1;
    @(negedge clk); chk("t6_read_in_rst", 32'(rd), 32'd0);
    cyc(); @(negedge clk);
    chk("t6_vld", 32'(vld), 32'd0); chk("t6_cnt", 32'(cnt), 32'd0); chk("t6_idle", 32'(idle), 32'd1);
    cyc(); rst = 1'b0; en = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 17; i++) write_word(32'h400 + 32'(i));
    en = 1'b1; rdy = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (exp_q.size() == 0 && !vld) break;
      cyc();
    end
    @(negedge clk);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_wrap_count", 32'(cnt), 32'd1);
    cyc(); cyc();
    @(negedge clk); chk("t6_idle_end", 32'(idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
